// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
// Module   : store_queue
// Purpose  : Aligns store requests to byte lanes, buffers them in a FIFO and
//            drains them one at a time over an addr_ok/data_ok write bus.
// Revision : 1.0  initial release
// ============================================================================
module store_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [2:0]  in_msize,
    input  logic [31:0] in_data,
    output logic        misalign,
    output logic        empty,
    input  logic [31:0] chk_addr,
    output logic        conflict,
    output logic        req_valid,
    output logic [31:0] req_addr,
    output logic [2:0]  req_size,
    output logic [3:0]  req_strobe,
    output logic [31:0] req_data,
    input  logic        addr_ok,
    input  logic        data_ok
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;

    logic [31:0]     r_addr   [DEPTH];
    logic [2:0]      r_size   [DEPTH];
    logic [3:0]      r_strobe [DEPTH];
    logic [31:0]     r_data   [DEPTH];

    logic            w_bad;
    logic [3:0]      w_strobe;
    logic [31:0]     w_wdata;
    logic            w_push;
    logic            w_pop;
    logic            w_remain;

    // Lane alignment; invalid size codes fall through to the default and are misaligned.
    always_comb begin
        w_bad    = 1'b1;
        w_strobe = 4'b0000;
        w_wdata  = in_data;
        case (in_msize)
            3'd0: begin
                w_bad    = 1'b0;
                w_strobe = 4'b0001 << in_addr[1:0];
                w_wdata  = {4{in_data[7:0]}};
            end
            3'd1: begin
                w_bad    = in_addr[0];
                w_strobe = 4'b0011 << in_addr[1:0];
                w_wdata  = {2{in_data[15:0]}};
            end
            3'd2: begin
                w_bad    = (in_addr[1:0] != 2'b00);
                w_strobe = 4'b1111;
            end
            default: ;
        endcase
    end

    assign misalign = in_valid && w_bad;
    assign in_ready = (r_count != C_DEPTH);
    assign empty    = (r_count == '0);
    assign w_push   = in_valid && in_ready && !w_bad;
    // Entries left after a pop, counting a push landing in the same cycle.
    assign w_remain = (r_count > (AW+1)'(1)) || w_push;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!empty || w_push) w_next = S_REQ;
            end
            S_REQ: begin
                if (addr_ok) begin
                    if (data_ok) begin
                        w_pop  = 1'b1;
                        w_next = w_remain ? S_REQ : S_IDLE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_ok) begin
                    w_pop  = 1'b1;
                    w_next = w_remain ? S_REQ : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail]   <= in_addr;
            r_size[r_tail]   <= in_msize;
            r_strobe[r_tail] <= w_strobe;
            r_data[r_tail]   <= w_wdata;
        end
    end

    assign req_valid  = (r_state == S_REQ);
    assign req_addr   = {r_addr[r_head][31:2], 2'b00};
    assign req_size   = r_size[r_head];
    assign req_strobe = r_strobe[r_head];
    assign req_data   = r_data[r_head];

    // A slot is live when its distance from head is below count.
    always_comb begin : conflict_scan
        logic [AW-1:0] off;
        conflict = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - r_head;
            if (({1'b0, off} < r_count) && (r_addr[i][31:2] == chk_addr[31:2]))
                conflict = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_queue
// Purpose  : Self-checking bench for store_queue against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_store_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, misalign, empty, conflict;
    logic [31:0] in_addr, in_data, chk_addr, req_addr, req_data;
    logic [2:0]  in_msize, req_size;
    logic [3:0]  req_strobe;
    logic        req_valid, addr_ok, data_ok;

    store_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_msize(in_msize), .in_data(in_data),
        .misalign(misalign), .empty(empty), .chk_addr(chk_addr), .conflict(conflict),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_strobe(req_strobe), .req_data(req_data),
        .addr_ok(addr_ok), .data_ok(data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;

    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2;

    ent_t mq[$];
    int   ph = PH_IDLE;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Store encoding from the alignment rules: n-byte access, replicated n-byte data.
    task automatic encode(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                          output logic bad, output logic [3:0] strb, output logic [31:0] wd);
        int n;
        n    = (sz <= 3'd2) ? (1 << sz) : 0;
        bad  = (n == 0) || ((a % n) != 0);
        strb = '0;
        wd   = '0;
        if (!bad) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= int'(a[1:0]) && b < int'(a[1:0]) + n) strb[b] = 1'b1;
                wd[8*b +: 8] = d[8*(b % n) +: 8];
            end
        end
    endtask

    task automatic step(input logic rs, input logic v, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input logic aok, input logic dok, input logic [31:0] ca);
        logic        bad, push, pop, hit;
        logic [3:0]  strb;
        logic [31:0] wd;
        ent_t        e;
        @(negedge clk);
        reset = rs; in_valid = v; in_addr = a; in_msize = sz; in_data = d;
        addr_ok = aok; data_ok = dok; chk_addr = ca;
        #1;
        encode(a, sz, d, bad, strb, wd);
        hit = 1'b0;
        foreach (mq[k]) if (mq[k].addr[31:2] == ca[31:2]) hit = 1'b1;
        check_eq("misalign", 32'(misalign), 32'(v && bad));
        check_eq("empty", 32'(empty), 32'(mq.size() == 0));
        check_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check_eq("conflict", 32'(conflict), 32'(hit));
        check_eq("req_valid", 32'(req_valid), 32'(ph == PH_REQ));
        if (ph == PH_REQ && mq.size() > 0) begin
            check_eq("req_addr", req_addr, {mq[0].addr[31:2], 2'b00});
            check_eq("req_size", 32'(req_size), 32'(mq[0].sz));
            check_eq("req_strobe", 32'(req_strobe), 32'(mq[0].strb));
            check_eq("req_data", req_data, mq[0].data);
        end
        if (rs) begin
            mq.delete();
            ph = PH_IDLE;
        end else begin
            push = v && (mq.size() < DEPTH) && !bad;
            pop  = 1'b0;
            case (ph)
                PH_IDLE: if (mq.size() != 0 || push) ph = PH_REQ;
                PH_REQ:  if (aok && dok) pop = 1'b1; else if (aok) ph = PH_WAIT;
                default: if (dok) pop = 1'b1;
            endcase
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.addr = a; e.sz = sz; e.strb = strb; e.data = wd;
                mq.push_back(e);
            end
            if (pop) ph = (mq.size() != 0) ? PH_REQ : PH_IDLE;
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_msize = '0; in_data = '0;
        addr_ok = 1'b0; data_ok = 1'b0; chk_addr = '0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        post_edge();
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_req_valid", 32'(req_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Byte store at lane 3.
        step(0, 1, 32'h1003, 3'd0, 32'h0000_00AB, 0, 0, 0);
        post_edge();
        check_eq("sb_req_valid", 32'(req_valid), 32'd1);
        check_eq("sb_req_addr", req_addr, 32'h0000_1000);
        check_eq("sb_strobe", 32'(req_strobe), 32'h8);
        check_eq("sb_data", req_data, 32'hABAB_ABAB);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        post_edge();
        check_eq("sb_drained", 32'(empty), 32'd1);

        // Misaligned halfword, then aligned halfword at upper lanes.
        step(0, 1, 32'h2001, 3'd1, 32'h0000_1234, 0, 0, 0);
        post_edge();
        check_eq("sh_mis_empty", 32'(empty), 32'd1);
        check_eq("sh_mis_req", 32'(req_valid), 32'd0);
        step(0, 1, 32'h2002, 3'd1, 32'h0000_1234, 0, 0, 0);
        post_edge();
        check_eq("sh_strobe", 32'(req_strobe), 32'hC);
        check_eq("sh_data", req_data, 32'h1234_1234);
        step(0, 0, 0, 0, 0, 1, 1, 0);

        // Fill to full with the bus stalled, attempt a 5th, then drain in order.
        for (int i = 0; i < 4; i++) step(0, 1, 32'h100 + 32'(i*4), 3'd2, 32'hD000_0000 + 32'(i), 0, 0, 0);
        post_edge();
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        step(0, 1, 32'h200, 3'd2, 32'hDEAD_0005, 0, 0, 0);
        step(0, 1, 32'h200, 3'd2, 32'hDEAD_0005, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1, 1, 0);

        // Load-conflict detection.
        step(0, 1, 32'h3004, 3'd2, 32'h5555_AAAA, 0, 0, 32'h3006);
        step(0, 0, 0, 0, 0, 0, 0, 32'h3006);
        check_eq("conf_hit", 32'(conflict), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 32'h3008);
        check_eq("conf_miss", 32'(conflict), 32'd0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h3006);
        step(0, 0, 0, 0, 0, 0, 0, 32'h3006);
        check_eq("conf_popped", 32'(conflict), 32'd0);

        // Reset while waiting for data_ok with three entries held.
        step(0, 1, 32'h400, 3'd2, 32'h1111_1111, 0, 0, 0);
        step(0, 1, 32'h404, 3'd2, 32'h2222_2222, 0, 0, 0);
        step(0, 1, 32'h408, 3'd2, 32'h3333_3333, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        post_edge();
        check_eq("wrst_empty", 32'(empty), 32'd1);
        check_eq("wrst_req_valid", 32'(req_valid), 32'd0);
        check_eq("wrst_in_ready", 32'(in_ready), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back pushes with the bus always completing.
        for (int i = 0; i < 200; i++)
            step(0, 1, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 3'd2, $urandom, 1, 1, 32'($urandom_range(0, 63)));

        // Fully random traffic with rare resets and invalid sizes.
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                 32'($urandom_range(0, 63)), 3'($urandom_range(0, 7) == 7 ? $urandom_range(3, 7) : $urandom_range(0, 2)),
                 $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0),
                 32'($urandom_range(0, 63)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
